// File: rtl/ccu_ctrl_snoop_collector.sv
// ---------------------------------------------------------------------------
// ccu_ctrl_snoop_collector
//
// Collects the snoop responses for one coherent transaction.
//   * Gathers one CR (snoop response) from every master in the snoop mask.
//   * ORs the response flags into a registered summary.
//   * Picks the lowest-index master that returned DataTransfer as the winner.
//   * Forwards the winner's CD beats to the downstream FIFO.
//   * Drains and drops the CD beats of every other data responder.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             begin a transaction (accepted only when idle)
//   snoop_mask_i        masters snooped, sampled together with start_i
//   busy_o              collection in progress (any state but IDLE)
//   cr_valid_i/ready_o  per-master CR handshake; cr_resp_i per-master CRRESP
//   cd_valid_i/ready_o  per-master CD handshake; cd_data_i, cd_last_i beat
//   cd_o                winner beat (combinational); cd_handshake_o beat pushed
//   cd_fifo_full_i      downstream CD FIFO full, back-pressures the winner
//   done_o              one-cycle completion pulse
//   data_avail_o, dirty_o, shared_o, error_o   registered response summary
//   first_responder_o   index of the forwarded (winning) responder
//   stall_cnt_o         cycles the winner was blocked by a full CD FIFO
//
// Build option
//   CCU_SNOOP_COLLECTOR_STALL_CNT_EN  adds the saturating 16-bit stall
//   counter; without it stall_cnt_o is tied to zero.
// ---------------------------------------------------------------------------
module ccu_ctrl_snoop_collector #(
  parameter int unsigned NoMstPorts      = 4,
  parameter int unsigned AxiDataWidth    = 64,
  parameter int unsigned DcacheLineWords = 2,
  parameter int unsigned MstIdxBits      = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      start_i,
  input  logic [NoMstPorts-1:0]                     snoop_mask_i,
  output logic                                      busy_o,
  input  logic [NoMstPorts-1:0]                     cr_valid_i,
  output logic [NoMstPorts-1:0]                     cr_ready_o,
  input  logic [NoMstPorts-1:0][4:0]                cr_resp_i,
  input  logic [NoMstPorts-1:0]                     cd_valid_i,
  output logic [NoMstPorts-1:0]                     cd_ready_o,
  input  logic [NoMstPorts-1:0][AxiDataWidth-1:0]   cd_data_i,
  input  logic [NoMstPorts-1:0]                     cd_last_i,
  output logic [AxiDataWidth-1:0]                   cd_o,
  output logic                                      cd_handshake_o,
  input  logic                                      cd_fifo_full_i,
  output logic                                      done_o,
  output logic                                      data_avail_o,
  output logic                                      dirty_o,
  output logic                                      shared_o,
  output logic                                      error_o,
  output logic [MstIdxBits-1:0]                     first_responder_o,
  output logic [15:0]                               stall_cnt_o
);

  localparam int unsigned BeatBits = (DcacheLineWords > 1) ? $clog2(DcacheLineWords) : 1;
  localparam logic [BeatBits-1:0] LastBeat = BeatBits'(DcacheLineWords - 1);

  // CRRESP bit positions
  localparam int unsigned RespDataTransfer = 0;
  localparam int unsigned RespError        = 1;
  localparam int unsigned RespPassDirty    = 2;
  localparam int unsigned RespIsShared     = 3;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT_CR,
    COLLECT_CD,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [NoMstPorts-1:0]   cr_pend_q, cr_pend_d;    // CR still outstanding
  logic [NoMstPorts-1:0]   cd_pend_q, cd_pend_d;    // CD burst still outstanding
  logic [MstIdxBits-1:0]   winner_q, winner_d;
  logic [BeatBits-1:0]     beat_cnt_q, beat_cnt_d;  // winner beats accepted
  logic                    data_avail_q, data_avail_d;
  logic                    dirty_q, dirty_d;
  logic                    shared_q, shared_d;
  logic                    error_q, error_d;

  logic [NoMstPorts-1:0]   cd_rdy;
  logic                    win_hs;
  logic                    win_last_beat;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    cr_pend_d      = cr_pend_q;
    cd_pend_d      = cd_pend_q;
    winner_d       = winner_q;
    beat_cnt_d     = beat_cnt_q;
    data_avail_d   = data_avail_q;
    dirty_d        = dirty_q;
    shared_d       = shared_q;
    error_d        = error_q;
    cr_ready_o     = '0;
    cd_rdy         = '0;
    cd_o           = '0;
    cd_handshake_o = 1'b0;
    done_o         = 1'b0;
    win_hs         = 1'b0;
    win_last_beat  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cr_pend_d    = snoop_mask_i;
          cd_pend_d    = '0;
          winner_d     = '0;
          beat_cnt_d   = '0;
          data_avail_d = 1'b0;
          dirty_d      = 1'b0;
          shared_d     = 1'b0;
          error_d      = 1'b0;
          state_d      = (snoop_mask_i == '0) ? DONE : COLLECT_CR;
        end
      end

      COLLECT_CR: begin
        cr_ready_o = cr_pend_q;
        // Ascending scan plus the index compare keeps the lowest-index data
        // responder as winner whatever order the CRs arrive in.
        for (int i = 0; i < NoMstPorts; i++) begin
          if (cr_valid_i[i] && cr_pend_q[i]) begin
            cr_pend_d[i] = 1'b0;
            dirty_d      = dirty_d  | cr_resp_i[i][RespPassDirty];
            shared_d     = shared_d | cr_resp_i[i][RespIsShared];
            error_d      = error_d  | cr_resp_i[i][RespError];
            if (cr_resp_i[i][RespDataTransfer]) begin
              cd_pend_d[i] = 1'b1;
              if (!data_avail_d || (MstIdxBits'(i) < winner_d)) begin
                winner_d = MstIdxBits'(i);
              end
              data_avail_d = 1'b1;
            end
          end
        end
        if (cr_pend_d == '0) begin
          state_d = data_avail_d ? COLLECT_CD : DONE;
        end
      end

      COLLECT_CD: begin
        // Losers are drained unconditionally; only the winner sees the FIFO.
        for (int i = 0; i < NoMstPorts; i++) begin
          if (cd_pend_q[i]) begin
            cd_rdy[i] = (MstIdxBits'(i) == winner_q) ? !cd_fifo_full_i : 1'b1;
          end
        end
        for (int i = 0; i < NoMstPorts; i++) begin
          if ((MstIdxBits'(i) != winner_q) && cd_valid_i[i] && cd_rdy[i] && cd_last_i[i]) begin
            cd_pend_d[i] = 1'b0;
          end
        end
        cd_o           = cd_data_i[winner_q];
        win_hs         = cd_pend_q[winner_q] && cd_valid_i[winner_q] && !cd_fifo_full_i;
        cd_handshake_o = win_hs;
        if (win_hs) begin
          win_last_beat = (beat_cnt_q == LastBeat);
          beat_cnt_d    = beat_cnt_q + BeatBits'(1);
          // A last flag in the wrong place is reported, but the burst still
          // ends so the transaction cannot hang on a misbehaving master.
          if (cd_last_i[winner_q] != win_last_beat) begin
            error_d = 1'b1;
          end
          if (cd_last_i[winner_q] || win_last_beat) begin
            cd_pend_d[winner_q] = 1'b0;
          end
        end
        if (cd_pend_d == '0) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cr_pend_q    <= '0;
      cd_pend_q    <= '0;
      winner_q     <= '0;
      beat_cnt_q   <= '0;
      data_avail_q <= 1'b0;
      dirty_q      <= 1'b0;
      shared_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cr_pend_q    <= cr_pend_d;
      cd_pend_q    <= cd_pend_d;
      winner_q     <= winner_d;
      beat_cnt_q   <= beat_cnt_d;
      data_avail_q <= data_avail_d;
      dirty_q      <= dirty_d;
      shared_q     <= shared_d;
      error_q      <= error_d;
    end
  end

  assign cd_ready_o        = cd_rdy;
  assign busy_o            = (state_q != IDLE);
  assign data_avail_o      = data_avail_q;
  assign dirty_o           = dirty_q;
  assign shared_o          = shared_q;
  assign error_o           = error_q;
  assign first_responder_o = winner_q;

`ifdef CCU_SNOOP_COLLECTOR_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Counts only while the winner actually holds a beat the FIFO refuses.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == COLLECT_CD) && cd_pend_q[winner_q] && cd_valid_i[winner_q] &&
        cd_fifo_full_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ccu_ctrl_snoop_collector.sv
// ---------------------------------------------------------------------------
// Bench for ccu_ctrl_snoop_collector. The bench plays every master: it keeps,
// per master, whether its CR has been taken and how many CD beats it has
// delivered. The expected collector phase is derived from those counts alone
// (CRs outstanding -> collecting CR; beats outstanding -> collecting CD;
// otherwise done), and the expected summary comes from ORing the responses.
// ---------------------------------------------------------------------------
module tb_ccu_ctrl_snoop_collector;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int L  = 2;
  localparam int IB = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 start_i;
  logic [N-1:0]         snoop_mask_i;
  logic                 busy_o;
  logic [N-1:0]         cr_valid_i;
  logic [N-1:0]         cr_ready_o;
  logic [N-1:0][4:0]    cr_resp_i;
  logic [N-1:0]         cd_valid_i;
  logic [N-1:0]         cd_ready_o;
  logic [N-1:0][W-1:0]  cd_data_i;
  logic [N-1:0]         cd_last_i;
  logic [W-1:0]         cd_o;
  logic                 cd_handshake_o;
  logic                 cd_fifo_full_i;
  logic                 done_o;
  logic                 data_avail_o;
  logic                 dirty_o;
  logic                 shared_o;
  logic                 error_o;
  logic [IB-1:0]        first_responder_o;
  logic [15:0]          stall_cnt_o;

  ccu_ctrl_snoop_collector #(
    .NoMstPorts      (N),
    .AxiDataWidth    (W),
    .DcacheLineWords (L)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .snoop_mask_i      (snoop_mask_i),
    .busy_o            (busy_o),
    .cr_valid_i        (cr_valid_i),
    .cr_ready_o        (cr_ready_o),
    .cr_resp_i         (cr_resp_i),
    .cd_valid_i        (cd_valid_i),
    .cd_ready_o        (cd_ready_o),
    .cd_data_i         (cd_data_i),
    .cd_last_i         (cd_last_i),
    .cd_o              (cd_o),
    .cd_handshake_o    (cd_handshake_o),
    .cd_fifo_full_i    (cd_fifo_full_i),
    .done_o            (done_o),
    .data_avail_o      (data_avail_o),
    .dirty_o           (dirty_o),
    .shared_o          (shared_o),
    .error_o           (error_o),
    .first_responder_o (first_responder_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_total = 0;

  // Per-transaction master state
  bit          cr_done [N];
  int          cr_wait [N];
  int          nbeats  [N];
  int          sent    [N];
  logic [W-1:0] bdata  [N][L];
  int          win;
  int          last_mode;   // 0 proper last, 1 winner ends early, 2 winner omits last

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_last(input int i, input int b);
    if (i == win) begin
      if (last_mode == 1) return (b == 0);
      if (last_mode == 2) return 1'b0;
    end
    return (b == L - 1);
  endfunction

  task automatic idle_inputs();
    start_i        = 1'b0;
    snoop_mask_i   = '0;
    cr_valid_i     = '0;
    cd_valid_i     = '0;
    cd_last_i      = '0;
    cd_fifo_full_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {busy_o, done_o, cr_ready_o, cd_ready_o, cd_handshake_o,
                          data_avail_o, dirty_o, shared_o, error_o, first_responder_o}, '0);
    check({tag, "_cd_o"}, cd_o, '0);
    check({tag, "_stall"}, stall_cnt_o, '0);
  endtask

  // fast >= 0: that master answers CR at once, the others 3 cycles later.
  // full_script >= 0: FIFO full for that many CD cycles, all pending masters valid.
  task automatic run_txn(input logic [N-1:0] mask, input logic [N-1:0][4:0] resps,
                         input int lmode, input int fast, input int full_pct,
                         input int full_script, input bit abort_in_cd);
    bit exp_da, exp_dirty, exp_shared, exp_err;
    bit all_cr, cd_any, in_cr, in_cd, in_done, exp_hs, done_seen;
    logic [N-1:0] exp_crr, exp_cdr;
    int cyc, cd_cyc, fwd;
    logic [15:0] exp_stall;

    win = -1;
    exp_da = 0; exp_dirty = 0; exp_shared = 0; exp_err = 0;
    for (int i = 0; i < N; i++) begin
      cr_done[i] = 1'b0;
      sent[i]    = 0;
      cr_wait[i] = (fast >= 0) ? ((i == fast) ? 0 : 3) : int'($urandom_range(0, 4));
      nbeats[i]  = (mask[i] && resps[i][0]) ? L : 0;
      for (int b = 0; b < L; b++) bdata[i][b] = {$urandom, $urandom};
      if (mask[i]) begin
        exp_dirty  |= resps[i][2];
        exp_shared |= resps[i][3];
        exp_err    |= resps[i][1];
        if (resps[i][0]) begin
          exp_da = 1'b1;
          if (win < 0) win = i;
        end
      end
    end
    last_mode = (win >= 0) ? lmode : 0;
    if (win >= 0 && last_mode == 1) nbeats[win] = 1;
    if (win >= 0 && last_mode != 0) exp_err = 1'b1;

    @(negedge clk_i);
    idle_inputs();
    start_i      = 1'b1;
    snoop_mask_i = mask;
    cr_resp_i    = resps;
    @(posedge clk_i);

    cyc = 0; cd_cyc = 0; fwd = 0; done_seen = 0;
    while (!done_seen) begin
      @(negedge clk_i);
      if (cyc >= 300) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: no done_o after %0d cycles, expected completion", cyc);
        break;
      end
      // start_i while busy must be ignored
      start_i      = ($urandom_range(0, 3) == 0);
      snoop_mask_i = N'($urandom);
      all_cr = 1'b1;
      cd_any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (mask[i] && !cr_done[i]) all_cr = 1'b0;
        if (sent[i] < nbeats[i])     cd_any = 1'b1;
      end
      in_cr   = !all_cr;
      in_cd   = all_cr && cd_any;
      in_done = all_cr && !cd_any;
      for (int i = 0; i < N; i++) begin
        cr_valid_i[i] = mask[i] ? (!cr_done[i] && cr_wait[i] == 0) : 1'($urandom_range(0, 1));
        if (sent[i] < nbeats[i]) begin
          cd_valid_i[i] = (full_script >= 0 && in_cd) ? 1'b1 : ($urandom_range(0, 9) < 7);
          cd_data_i[i]  = bdata[i][sent[i]];
          cd_last_i[i]  = is_last(i, sent[i]);
        end else begin
          cd_valid_i[i] = 1'($urandom_range(0, 1));
          cd_data_i[i]  = {$urandom, $urandom};
          cd_last_i[i]  = 1'($urandom_range(0, 1));
        end
      end
      cd_fifo_full_i = (full_script >= 0) ? (in_cd && cd_cyc < full_script)
                                          : ($urandom_range(0, 99) < full_pct);
      #1;
      exp_crr = '0;
      exp_cdr = '0;
      exp_hs  = 1'b0;
      if (in_cr) for (int i = 0; i < N; i++) exp_crr[i] = mask[i] && !cr_done[i];
      if (in_cd) begin
        for (int i = 0; i < N; i++)
          if (sent[i] < nbeats[i]) exp_cdr[i] = (i == win) ? !cd_fifo_full_i : 1'b1;
        exp_hs = (sent[win] < nbeats[win]) && cd_valid_i[win] && !cd_fifo_full_i;
        if ((sent[win] < nbeats[win]) && cd_valid_i[win] && cd_fifo_full_i) stall_total++;
      end
      check("busy", busy_o, 1'b1);
      check("done", done_o, in_done);
      check("cr_ready", cr_ready_o, exp_crr);
      check("cd_ready", cd_ready_o, exp_cdr);
      check("cd_handshake", cd_handshake_o, exp_hs);
      if (exp_hs) check("cd_o", cd_o, bdata[win][sent[win]]);

      if (abort_in_cd && in_cd) begin
        rst_i = 1'b1;
        #1;
        check_all_zero("abort");
        @(posedge clk_i);
        #2;
        idle_inputs();
        rst_i       = 1'b0;
        stall_total = 0;
        return;
      end

      for (int i = 0; i < N; i++) begin
        if (in_cr && cr_valid_i[i] && exp_crr[i]) cr_done[i] = 1'b1;
        if (cr_wait[i] > 0) cr_wait[i]--;
        if (in_cd && cd_valid_i[i] && exp_cdr[i]) begin
          sent[i]++;
          if (i == win) fwd++;
        end
      end
      if (in_cd) cd_cyc++;
      if (in_done) done_seen = 1'b1;
      cyc++;
    end

    // Cycle after DONE: back in IDLE, summary holds
    @(negedge clk_i);
    idle_inputs();
    #1;
`ifdef CCU_SNOOP_COLLECTOR_STALL_CNT_EN
    exp_stall = (stall_total > 16'hFFFF) ? 16'hFFFF : 16'(stall_total);
`else
    exp_stall = '0;
`endif
    check("idle_busy", busy_o, 1'b0);
    check("idle_done", done_o, 1'b0);
    check("data_avail", data_avail_o, exp_da);
    check("dirty", dirty_o, exp_dirty);
    check("shared", shared_o, exp_shared);
    check("error", error_o, exp_err);
    check("first_responder", first_responder_o, (win >= 0) ? IB'(win) : '0);
    check("fwd_beats", fwd, (win >= 0) ? nbeats[win] : 0);
    check("stall_cnt", stall_cnt_o, exp_stall);
  endtask

  initial begin
    logic [N-1:0][4:0] r;
    logic [N-1:0]      m;
    int                lm;

    rst_i     = 1'b1;
    cr_resp_i = '0;
    cd_data_i = '0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check_all_zero("reset");
    // Release mid-phase so the start driven at the next falling edge is
    // taken on the very first rising edge without reset.
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;

    // m1 plain, m2 DataTransfer + PassDirty
    run_txn(4'b0110, {5'b00000, 5'b00101, 5'b00000, 5'b00000}, 0, -1, 0, -1, 1'b0);
    // m3 answers first, m1 still wins; m3 beats drained
    run_txn(4'b1010, {5'b00001, 5'b00000, 5'b00001, 5'b00000}, 0, 3, 0, -1, 1'b0);
    // empty mask
    run_txn(4'b0000, '0, 0, -1, 0, -1, 1'b0);
    // FIFO full for three CD cycles
    run_txn(4'b0001, {5'b00000, 5'b00000, 5'b00000, 5'b01001}, 0, -1, 0, 3, 1'b0);
    // winner flags last on beat 0
    run_txn(4'b0100, {5'b00000, 5'b00001, 5'b00000, 5'b00000}, 1, -1, 0, -1, 1'b0);
    // winner never flags last
    run_txn(4'b1001, {5'b10001, 5'b00000, 5'b00000, 5'b00011}, 2, -1, 20, -1, 1'b0);
    // reset during CD collection, then a normal transaction
    run_txn(4'b0011, {5'b00000, 5'b00000, 5'b00001, 5'b00001}, 0, -1, 0, -1, 1'b1);
    run_txn(4'b0011, {5'b00000, 5'b00000, 5'b00001, 5'b00001}, 0, -1, 30, -1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      m = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) r[i] = 5'($urandom);
      lm = int'($urandom_range(0, 5));
      if (lm > 2) lm = 0;
      run_txn(m, r, lm, -1, int'($urandom_range(0, 60)), -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ccu_ctrl_snoop_collector.md
CCU_CTRL_SNOOP_COLLECTOR -- requirements
Module: ccu_ctrl_snoop_collector

Interface
REQ-001 Parameter NoMstPorts, default 4, number of snooped masters; MstIdxBits = clog2(NoMstPorts).
REQ-002 Parameter AxiDataWidth, default 64, CD beat width.
REQ-003 Parameter DcacheLineWords, default 2, CD beats per cache line.
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 start_i  in  1  begin collection for one snoop transaction.
REQ-007 snoop_mask_i  in  NoMstPorts  masters snooped by this transaction, sampled with start_i.
REQ-008 busy_o  out  1  collection in progress.
REQ-009 cr_valid_i / cr_ready_o  in/out  NoMstPorts each  per-master CR handshake.
REQ-010 cr_resp_i  in  NoMstPorts x 5  CRRESP: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
REQ-011 cd_valid_i / cd_ready_o  in/out  NoMstPorts each  per-master CD handshake.
REQ-012 cd_data_i  in  NoMstPorts x AxiDataWidth  CD data; cd_last_i  in  NoMstPorts  CD last.
REQ-013 cd_o  out  AxiDataWidth  forwarded winner beat; cd_handshake_o  out  1  beat pushed this cycle.
REQ-014 cd_fifo_full_i  in  1  downstream CD FIFO full.
REQ-015 done_o  out  1  one-cycle pulse, transaction complete.
REQ-016 data_avail_o, dirty_o, shared_o, error_o  out  1 each  registered summary.
REQ-017 first_responder_o  out  MstIdxBits  index of forwarded responder.
REQ-018 stall_cnt_o  out  16  CD-full stall counter (see Configuration).

Function
REQ-019 FSM states SHALL be IDLE, COLLECT_CR, COLLECT_CD, DONE.
REQ-020 IDLE: start_i=1 captures snoop_mask_i, clears summary, goes COLLECT_CR; start_i outside IDLE is ignored.
REQ-021 start_i with snoop_mask_i=0 goes directly to DONE; done_o next cycle, data_avail_o=0.
REQ-022 COLLECT_CR: cr_ready_o[i]=1 only for masked masters whose CR is still pending; each handshake clears its pending bit.
REQ-023 Summary ORs across responses: dirty |= PassDirty, shared |= IsShared, error |= Error, data_avail |= DataTransfer.
REQ-024 Winner = lowest-index master with DataTransfer=1, independent of CR arrival order; recorded in first_responder_o.
REQ-025 Last CR handshake moves to COLLECT_CD if any DataTransfer seen, else to DONE.
REQ-026 cd_ready_o SHALL be 0 outside COLLECT_CD.
REQ-027 COLLECT_CD, non-winner with DataTransfer: cd_ready_o=1, beats discarded.
REQ-028 COLLECT_CD, winner: cd_ready_o = !cd_fifo_full_i; cd_handshake_o = winner cd_valid_i & !cd_fifo_full_i; cd_o = winner cd_data_i, combinational, same cycle.
REQ-029 Winner beat counter 0..DcacheLineWords-1 SHALL increment per accepted beat; cd_last_i on a beat other than DcacheLineWords-1, or missing on that beat, sets error_o; the beat still completes that responder.
REQ-030 Each data responder's CD pending bit clears on its last-beat handshake; all clear -> DONE.
REQ-031 DONE: done_o=1 for exactly one cycle, then IDLE; summary and first_responder_o hold until the next accepted start_i.
REQ-032 busy_o=1 in every state except IDLE.
REQ-033 CR and CD handshakes for the same master in the same cycle SHALL NOT occur: CD readiness starts only after the state transition.

Reset
REQ-034 rst_i=1 SHALL asynchronously force IDLE, clear masks, counters and summary; all outputs 0, including mid-transaction.
REQ-035 After reset release, the first start_i is honoured on the first rising edge with rst_i=0.

Configuration
REQ-036 Macro CCU_SNOOP_COLLECTOR_STALL_CNT_EN defined: stall_cnt_o counts cycles in COLLECT_CD where the winner has cd_valid_i=1 and cd_fifo_full_i=1; 16-bit, saturating at 0xFFFF, cleared only by reset.
REQ-037 Macro undefined: stall_cnt_o tied to 0 and no counter logic is instantiated.

Verification
REQ-038 mask=4'b0110, CR m1=00000, m2=00101 -> winner 2, dirty_o=1, two beats 0xA,0xB on cd_o with cd_handshake_o, done_o once.
REQ-039 mask=4'b1010, both DataTransfer, m3 CR before m1 -> first_responder_o=1; m3 beats drained, none forwarded.
REQ-040 mask=0 -> done_o one cycle after start_i, data_avail_o=0, no cr_ready_o asserted.
REQ-041 Winner beats with cd_fifo_full_i=1 for 3 cycles -> cd_ready_o=0, no handshake; stall_cnt_o=3 with macro, 0 without.
REQ-042 Winner cd_last_i on beat 0 with DcacheLineWords=2 -> error_o=1, DONE reached.
REQ-043 rst_i pulsed in COLLECT_CD -> busy_o=0, all outputs 0 immediately; next start_i runs normally.
